mips32_fetch_stage: RTL and testbench

//   IF stage of the MIPS32 pipeline: owns the PC, reads instruction memory and loads the IF/ID

---
 rtl/mips32_pkg.sv | 16 +
 rtl/mips32_fetch_stage.sv | 123 ++++++++++++
 tb/tb_mips32_fetch_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline constants and the fetch-side halt state encoding.
// Decode and writeback halt logic also use these.
package mips32_pkg;

  localparam int unsigned WordW = 32;

  localparam logic [5:0]       OPC_HLT  = 6'h3f;
  localparam logic [WordW-1:0] NOP_WORD = 32'h0e94a000;  // OR R20,R20,R20

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StHaltPend = 2'd1,
    StHalted   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mips32_fetch_stage.sv
// MIPS32 IF stage: owns the PC, reads instruction memory and loads the IF/ID register.
// Handles the ID stall, the downstream branch redirect and the fetch-side halt.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int unsigned IMEM_AW   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               br_taken_i,
  input  logic [31:0]        br_target_i,
  input  logic               halt_commit_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic               imem_rd_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        if_id_ir_o,
  output logic [31:0]        if_id_npc_o,
  output logic               if_id_valid_o,
  output logic [31:0]        pc_o,
  output logic               halted_o,
  output logic [31:0]        fetch_cnt_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  npc_q, npc_d;
  logic         valid_q, valid_d;
  logic [31:0]  cnt_q, cnt_d;

  logic [31:0] pc_inc;
  logic        fetch_is_hlt;

  assign pc_inc       = pc_q + 32'd1;
  assign fetch_is_hlt = (imem_rdata_i[31:26] == OPC_HLT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Commit beats redirect beats stall; HALTED is sticky until reset.
  always_comb begin
    state_d = state_q;
    if (halt_commit_i) begin
      state_d = StHalted;
    end else begin
      unique case (state_q)
        StRun: begin
          if (br_taken_i)                   state_d = StRun;
          else if (!stall_i && fetch_is_hlt) state_d = StHaltPend;
        end
        StHaltPend: begin
          if (br_taken_i) state_d = StRun;
        end
        StHalted: state_d = StHalted;
        default:  state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (halt_commit_i) begin
      ir_d    = NOP_INSTR;
      npc_d   = 32'd0;
      valid_d = 1'b0;
    end else if (state_q != StHalted) begin
      if (br_taken_i) begin
        pc_d    = br_target_i;
        ir_d    = NOP_INSTR;
        npc_d   = 32'd0;
        valid_d = 1'b0;
      end else if (!stall_i) begin
        if (state_q == StRun) begin
          // A fetched HLT is loaded normally; the PC then stays frozen at pc+1.
          pc_d    = pc_inc;
          ir_d    = imem_rdata_i;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          ir_d    = NOP_INSTR;
          npc_d   = 32'd0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    imem_rd_o = (state_q == StRun);
    halted_o  = (state_q == StHalted);
  end

  assign imem_addr_o   = pc_q[IMEM_AW-1:0];
  assign pc_o          = pc_q;
  assign if_id_ir_o    = ir_q;
  assign if_id_npc_o   = npc_q;
  assign if_id_valid_o = valid_q;
  assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mips32_fetch_stage.sv
// Directed bench for mips32_fetch_stage with a combinational instruction memory model.
module tb_mips32_fetch_stage;

  localparam int unsigned AW = 10;
  localparam logic [31:0] NOP = 32'h0e94a000;

  logic          clk = 1'b0;
  logic          rst, stall, br_taken, halt_commit;
  logic [31:0]   br_target;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [31:0]   imem_rdata;
  logic [31:0]   ir, npc, pc, cnt;
  logic          valid, halted;

  logic [31:0] mem [1024];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  mips32_fetch_stage #(
    .RESET_PC (32'h0),
    .NOP_INSTR(NOP),
    .IMEM_AW  (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .halt_commit_i(halt_commit),
    .imem_addr_o  (imem_addr),
    .imem_rd_o    (imem_rd),
    .imem_rdata_i (imem_rdata),
    .if_id_ir_o   (ir),
    .if_id_npc_o  (npc),
    .if_id_valid_o(valid),
    .pc_o         (pc),
    .halted_o     (halted),
    .fetch_cnt_o  (cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; halt_commit = 1'b0; br_target = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc !== 32'h0)  begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
    n_cmp++; if (ir !== NOP)    begin n_err++; $display("FAIL reset_ir got %h want %h", ir, NOP); end
    n_cmp++; if (npc !== 32'h0) begin n_err++; $display("FAIL reset_npc got %h want 0", npc); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", cnt); end
    n_cmp++; if (imem_rd !== 1'b1) begin n_err++; $display("FAIL reset_rd got %b want 1", imem_rd); end
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_ir [4];
    exp_ir[0] = 32'h2001000a; exp_ir[1] = 32'h20020014;
    exp_ir[2] = 32'h00221825; exp_ir[3] = 32'h8c040000;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (ir !== exp_ir[k])
        begin n_err++; $display("FAIL straight_ir[%0d] got %h want %h", k, ir, exp_ir[k]); end
      n_cmp++; if (npc !== 32'(k + 1))
        begin n_err++; $display("FAIL straight_npc[%0d] got %0d want %0d", k, npc, k + 1); end
      n_cmp++; if (valid !== 1'b1)
        begin n_err++; $display("FAIL straight_valid[%0d] got %b want 1", k, valid); end
    end
    n_cmp++; if (cnt !== 32'd4) begin n_err++; $display("FAIL straight_cnt got %0d want 4", cnt); end
    n_cmp++; if (pc !== 32'd4)  begin n_err++; $display("FAIL straight_pc got %0d want 4", pc); end
  endtask

  task automatic test_stall();
    do_reset();
    run(2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (pc !== 32'd2)
        begin n_err++; $display("FAIL stall_pc[%0d] got %0d want 2", k, pc); end
      n_cmp++; if (ir !== 32'h20020014)
        begin n_err++; $display("FAIL stall_ir[%0d] got %h want 20020014", k, ir); end
      n_cmp++; if (cnt !== 32'd2)
        begin n_err++; $display("FAIL stall_cnt[%0d] got %0d want 2", k, cnt); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (ir !== 32'h00221825) begin n_err++; $display("FAIL stall_rel_ir got %h want 00221825", ir); end
    n_cmp++; if (npc !== 32'd3) begin n_err++; $display("FAIL stall_rel_npc got %0d want 3", npc); end
    n_cmp++; if (cnt !== 32'd3) begin n_err++; $display("FAIL stall_rel_cnt got %0d want 3", cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    run(9);
    stall = 1'b1; br_taken = 1'b1; br_target = 32'd5;
    step();
    stall = 1'b0; br_taken = 1'b0;
    n_cmp++; if (pc !== 32'd5)  begin n_err++; $display("FAIL redir_pc got %0d want 5", pc); end
    n_cmp++; if (ir !== NOP)    begin n_err++; $display("FAIL redir_ir got %h want %h", ir, NOP); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b want 0", valid); end
    n_cmp++; if (cnt !== 32'd9) begin n_err++; $display("FAIL redir_cnt got %0d want 9", cnt); end
    step();
    n_cmp++; if (ir !== 32'h14431000) begin n_err++; $display("FAIL redir_next_ir got %h want 14431000", ir); end
    n_cmp++; if (npc !== 32'd6) begin n_err++; $display("FAIL redir_next_npc got %0d want 6", npc); end
    n_cmp++; if (cnt !== 32'd10) begin n_err++; $display("FAIL redir_next_cnt got %0d want 10", cnt); end
  endtask

  task automatic test_wrong_path_hlt();
    do_reset();
    run(11);
    n_cmp++; if (ir !== 32'hfc000000) begin n_err++; $display("FAIL hlt_ir got %h want fc000000", ir); end
    n_cmp++; if (pc !== 32'd11) begin n_err++; $display("FAIL hlt_pc got %0d want 11", pc); end
    n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL hlt_rd got %b want 0", imem_rd); end
    step();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL hltpend_valid got %b want 0", valid); end
    n_cmp++; if (pc !== 32'd11) begin n_err++; $display("FAIL hltpend_pc got %0d want 11", pc); end
    br_taken = 1'b1; br_target = 32'd5;
    step();
    br_taken = 1'b0;
    n_cmp++; if (pc !== 32'd5) begin n_err++; $display("FAIL cancel_pc got %0d want 5", pc); end
    n_cmp++; if (imem_rd !== 1'b1) begin n_err++; $display("FAIL cancel_rd got %b want 1", imem_rd); end
    step();
    n_cmp++; if (ir !== 32'h14431000) begin n_err++; $display("FAIL cancel_ir got %h want 14431000", ir); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL cancel_halted got %b want 0", halted); end
  endtask

  task automatic test_halt_commit();
    int bad = 0;
    do_reset();
    run(11);
    halt_commit = 1'b1; br_taken = 1'b1; br_target = 32'd5;
    step();
    halt_commit = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL commit_halted got %b want 1", halted); end
    n_cmp++; if (pc !== 32'd11) begin n_err++; $display("FAIL commit_pc got %0d want 11", pc); end
    n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL commit_rd got %b want 0", imem_rd); end
    for (int k = 0; k < 20; k++) begin
      br_taken = k[0]; stall = k[1]; br_target = 32'd3;
      step();
      n_cmp++; if (pc !== 32'd11 || halted !== 1'b1 || valid !== 1'b0) begin
        n_err++;
        $display("FAIL halted_hold[%0d] got pc=%0d halted=%b valid=%b want 11/1/0",
                 k, pc, halted, valid);
      end
    end
    br_taken = 1'b0; stall = 1'b0;
    n_cmp++; if (cnt !== 32'd11) begin n_err++; $display("FAIL halted_cnt got %0d want 11", cnt); end
  endtask

  task automatic test_reset_and_wrap();
    do_reset();
    run(11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (pc !== 32'd0 || valid !== 1'b0 || cnt !== 32'd0 || imem_rd !== 1'b1) begin
      n_err++;
      $display("FAIL midreset got pc=%0d valid=%b cnt=%0d rd=%b want 0/0/0/1", pc, valid, cnt, imem_rd);
    end
    br_taken = 1'b1; br_target = 32'hffff_ffff;
    step();
    br_taken = 1'b0;
    n_cmp++; if (imem_addr !== 10'h3ff) begin n_err++; $display("FAIL wrap_addr_hi got %h want 3ff", imem_addr); end
    step();
    n_cmp++; if (pc !== 32'd0) begin n_err++; $display("FAIL wrap_pc got %h want 0", pc); end
    n_cmp++; if (imem_addr !== 10'h0) begin n_err++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    n_cmp++; if (npc !== 32'd0) begin n_err++; $display("FAIL wrap_npc got %h want 0", npc); end
    n_cmp++; if (ir !== 32'h200003ff) begin n_err++; $display("FAIL wrap_ir got %h want 200003ff", ir); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0]  = 32'h2001000a;
    mem[1]  = 32'h20020014;
    mem[2]  = 32'h00221825;
    mem[3]  = 32'h8c040000;
    mem[5]  = 32'h14431000;
    mem[10] = 32'hfc000000;
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_wrong_path_hlt();
    test_halt_commit();
    test_reset_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
